// File: rtl/lfsr_gen.sv
// lfsr_gen: parameterised Fibonacci/Galois LFSR, STEPS steps per enabled clock.
// Synchronous parallel load; an all-zero state or load is forced to 1 and flagged on zero_fix.
// Optional macro LFSR_GEN_PERIOD_EN adds cycle-length measurement (period, wrap).
module lfsr_gen #(
  parameter int               WIDTH = 26,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(26'h20000C1),
  parameter int               MODE  = 0,
  parameter int               STEPS = 1,
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic             zero_fix
`ifdef LFSR_GEN_PERIOD_EN
  ,
  output logic [WIDTH-1:0] period,
  output logic             wrap
`endif
);

  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] SEED_EFF = (SEED == '0) ? ONE : SEED;

  // One LFSR step in the selected topology.
  function automatic logic [WIDTH-1:0] step1(input logic [WIDTH-1:0] s);
    if (MODE == 0) return {s[WIDTH-2:0], ^(s & TAPS)};
    else           return {s[WIDTH-2:0], 1'b0} ^ (TAPS & {WIDTH{s[WIDTH-1]}});
  endfunction

  // Chain of STEPS single steps, all resolved within one clock.
  logic [STEPS:0][WIDTH-1:0] chain;
  assign chain[0] = q;
  for (genvar s = 0; s < STEPS; s++) begin : g_step
    assign chain[s+1] = step1(chain[s]);
  end

  logic [WIDTH-1:0] q_nxt;
  logic             zf_nxt;

  // Next state: load beats en; zero load/state is forced to 1.
  always_comb begin
    q_nxt  = q;
    zf_nxt = 1'b0;
    if (load) begin
      if (din == '0) begin
        q_nxt  = ONE;
        zf_nxt = 1'b1;
      end else begin
        q_nxt  = din;
      end
    end else if (en) begin
      if (q == '0) begin
        q_nxt  = ONE;
        zf_nxt = 1'b1;
      end else begin
        q_nxt  = chain[STEPS];
      end
    end
  end

  // State register with synchronous reset to the (non-zero) seed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q        <= SEED_EFF;
      zero_fix <= 1'b0;
    end else begin
      q        <= q_nxt;
      zero_fix <= zf_nxt;
    end
  end

`ifdef LFSR_GEN_PERIOD_EN
  logic [WIDTH-1:0] ref_val;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_inc;

  // Saturating step count, including the step being taken now.
  assign cnt_inc = (&cnt) ? cnt : cnt + ONE;

  // Period measurement: reference is the last reset/load value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ref_val <= SEED_EFF;
      cnt     <= '0;
      period  <= '0;
      wrap    <= 1'b0;
    end else if (load) begin
      ref_val <= q_nxt;
      cnt     <= '0;
      wrap    <= 1'b0;
    end else if (en) begin
      if (q_nxt == ref_val) begin
        wrap   <= 1'b1;
        period <= cnt_inc;
        cnt    <= '0;
      end else begin
        wrap   <= 1'b0;
        cnt    <= cnt_inc;
      end
    end else begin
      wrap    <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_lfsr_gen.sv
// tb_lfsr_gen: four lfsr_gen configurations driven in lockstep, checked every
// cycle against a behavioural model plus hand-computed sequence values.
module tb_lfsr_gen;

  logic        clk = 1'b0;
  logic        rst_n, en, load;
  logic [25:0] din26;
  logic [3:0]  din4;

  logic [25:0] q0;
  logic [3:0]  q1, q2, q3;
  logic        zf0, zf1, zf2, zf3;
`ifdef LFSR_GEN_PERIOD_EN
  logic [25:0] per0;
  logic [3:0]  per1, per2, per3;
  logic        wr0, wr1, wr2, wr3;
`endif

  always #5 clk = ~clk;

  lfsr_gen u0 (.clk(clk), .rst_n(rst_n), .en(en), .load(load), .din(din26), .q(q0), .zero_fix(zf0)
`ifdef LFSR_GEN_PERIOD_EN
    , .period(per0), .wrap(wr0)
`endif
  );
  lfsr_gen #(.WIDTH(4), .TAPS(4'b1001), .MODE(0), .STEPS(1)) u1 (.clk(clk), .rst_n(rst_n), .en(en),
    .load(load), .din(din4), .q(q1), .zero_fix(zf1)
`ifdef LFSR_GEN_PERIOD_EN
    , .period(per1), .wrap(wr1)
`endif
  );
  lfsr_gen #(.WIDTH(4), .TAPS(4'b0011), .MODE(1), .STEPS(1)) u2 (.clk(clk), .rst_n(rst_n), .en(en),
    .load(load), .din(din4), .q(q2), .zero_fix(zf2)
`ifdef LFSR_GEN_PERIOD_EN
    , .period(per2), .wrap(wr2)
`endif
  );
  lfsr_gen #(.WIDTH(4), .TAPS(4'b1001), .MODE(0), .STEPS(2)) u3 (.clk(clk), .rst_n(rst_n), .en(en),
    .load(load), .din(din4), .q(q3), .zero_fix(zf3)
`ifdef LFSR_GEN_PERIOD_EN
    , .period(per3), .wrap(wr3)
`endif
  );

  localparam int          W  [4] = '{26, 4, 4, 4};
  localparam logic [63:0] TP [4] = '{64'h20000C1, 64'h9, 64'h3, 64'h9};
  localparam int          MD [4] = '{0, 0, 1, 0};
  localparam int          ST [4] = '{1, 1, 1, 2};

  int n_chk = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Behavioural model: integer arithmetic straight from the stepping rules.
  function automatic logic [63:0] model_step(input logic [63:0] v, input int k);
    logic [63:0] mask, fb;
    mask = (64'd1 << W[k]) - 64'd1;
    if (MD[k] == 0) begin
      fb = 0;
      for (int i = 0; i < W[k]; i++) if (TP[k][i]) fb = fb ^ 64'(v[i]);
      return ((v << 1) | fb) & mask;
    end
    return ((v << 1) & mask) ^ (v[W[k]-1] ? TP[k] : 64'd0);
  endfunction

  logic [63:0] m_q [4];
  logic        m_zf[4];
  logic [63:0] m_cnt[4], m_ref[4], m_per[4];
  logic        m_wrap[4];

  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      logic [63:0] d, mask, nc;
      mask = (64'd1 << W[k]) - 64'd1;
      d    = (k == 0) ? 64'(din26) : 64'(din4);
      if (!rst_n) begin
        m_q[k] = 1; m_zf[k] = 0; m_cnt[k] = 0; m_ref[k] = 1; m_per[k] = 0; m_wrap[k] = 0;
      end else if (load) begin
        m_zf[k] = (d == 0); m_q[k] = (d == 0) ? 64'd1 : d;
        m_ref[k] = m_q[k]; m_cnt[k] = 0; m_wrap[k] = 0;
      end else if (en) begin
        if (m_q[k] == 0) begin
          m_q[k] = 1; m_zf[k] = 1;
        end else begin
          for (int s = 0; s < ST[k]; s++) m_q[k] = model_step(m_q[k], k);
          m_zf[k] = 0;
        end
        nc = (m_cnt[k] == mask) ? m_cnt[k] : m_cnt[k] + 1;
        if (m_q[k] == m_ref[k]) begin
          m_wrap[k] = 1; m_per[k] = nc; m_cnt[k] = 0;
        end else begin
          m_wrap[k] = 0; m_cnt[k] = nc;
        end
      end else begin
        m_zf[k] = 0; m_wrap[k] = 0;
      end
    end
  end

  // Per-cycle comparison of all instances against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("q0", 64'(q0), m_q[0]);   chk("zf0", 64'(zf0), 64'(m_zf[0]));
      chk("q1", 64'(q1), m_q[1]);   chk("zf1", 64'(zf1), 64'(m_zf[1]));
      chk("q2", 64'(q2), m_q[2]);   chk("zf2", 64'(zf2), 64'(m_zf[2]));
      chk("q3", 64'(q3), m_q[3]);   chk("zf3", 64'(zf3), 64'(m_zf[3]));
`ifdef LFSR_GEN_PERIOD_EN
      chk("wrap0", 64'(wr0), 64'(m_wrap[0])); chk("period0", 64'(per0), m_per[0]);
      chk("wrap1", 64'(wr1), 64'(m_wrap[1])); chk("period1", 64'(per1), m_per[1]);
      chk("wrap2", 64'(wr2), 64'(m_wrap[2])); chk("period2", 64'(per2), m_per[2]);
      chk("wrap3", 64'(wr3), 64'(m_wrap[3])); chk("period3", 64'(per3), m_per[3]);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [3:0] fib_seq [5] = '{4'h3, 4'h7, 4'hF, 4'hE, 4'hD};
  logic [3:0] gal_seq [5] = '{4'h2, 4'h4, 4'h8, 4'h3, 4'h6};

  initial begin
    rst_n = 1'b0; en = 1'b0; load = 1'b0; din26 = '0; din4 = '0;
    tick();
    chk_on = 1'b1;
    tick();
    chk("reset q0", 64'(q0), 64'd1);
    chk("reset zf0", 64'(zf0), 64'd0);
    chk("reset q1", 64'(q1), 64'd1);

    // Hand-computed sequences from reset.
    rst_n = 1'b1; en = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (i < 5) begin
        chk("fib seq", 64'(q1), 64'(fib_seq[i]));
        chk("gal seq", 64'(q2), 64'(gal_seq[i]));
      end
      if (i == 0) chk("steps2 first", 64'(q3), 64'h7);
      if (i == 1) chk("steps2 second", 64'(q3), 64'hE);
`ifdef LFSR_GEN_PERIOD_EN
      if (i == 13) chk("fib no wrap early", 64'(wr1), 64'd0);
      if (i == 14) begin
        chk("fib wrap", 64'(wr1), 64'd1);
        chk("fib period", 64'(per1), 64'd15);
        chk("gal period", 64'(per2), 64'd15);
      end
`endif
    end
    en = 1'b0;
    tick();
    chk("hold q1", 64'(q1), 64'd1);

    // Zero load is forced to 1 and flagged for exactly one cycle.
    load = 1'b1; din26 = '0; din4 = '0;
    tick();
    chk("zero load q0", 64'(q0), 64'd1);
    chk("zero load zf0", 64'(zf0), 64'd1);
    load = 1'b0;
    tick();
    chk("zf0 pulse end", 64'(zf0), 64'd0);

    // Load with en: loaded value is not stepped.
    load = 1'b1; en = 1'b1; din26 = 26'h155; din4 = 4'h5;
    tick();
    chk("load+en q0", 64'(q0), 64'h155);
    chk("load+en zf0", 64'(zf0), 64'd0);
    load = 1'b0;
    repeat (7) tick();

    // Reset overrides load and en; stepping resumes from the seed.
    rst_n = 1'b0; load = 1'b1; en = 1'b1; din26 = 26'h3A5; din4 = 4'hA;
    tick();
    chk("mid reset q0", 64'(q0), 64'd1);
    chk("mid reset zf0", 64'(zf0), 64'd0);
    rst_n = 1'b1; load = 1'b0; en = 1'b0;
    tick();
    en = 1'b1;
    tick();
    chk("resume q0", 64'(q0), 64'd3);

    // Long free run against the model.
    repeat (10000) tick();

    // Mixed traffic exercising priority and hold.
    for (int i = 0; i < 300; i++) begin
      en    = ($urandom_range(0, 3) != 0);
      load  = ($urandom_range(0, 15) == 0);
      din26 = ($urandom_range(0, 3) == 0) ? 26'd0 : 26'($urandom);
      din4  = 4'($urandom_range(0, 15));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
